// File: rtl/mode_cmd_pkg.sv
// mode_cmd_pkg: shared token, ASCII and RX FSM types for mode_cmd_arbiter.
// Token = 3-bit opcode plus 4-bit value (used by LR_SET only).
package mode_cmd_pkg;

  typedef enum logic [2:0] {
    TOK_LR_DEC,
    TOK_LR_INC,
    TOK_UD_DEC,
    TOK_UD_INC,
    TOK_LR_SET
  } tok_op_e;

  typedef struct packed {
    tok_op_e    op;
    logic [3:0] val;
  } tok_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_L    = 8'h4C;
  localparam logic [7:0] ASC_R    = 8'h52;
  localparam logic [7:0] ASC_U    = 8'h55;
  localparam logic [7:0] ASC_D    = 8'h44;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_CASE = 8'h20;

  function automatic logic ci_match(
    input logic [7:0] b,
    input logic [7:0] up
  );
    return (b == up) || (b == (up | ASC_CASE));
  endfunction

endpackage

// File: rtl/mode_cmd_fifo.sv
// mode_cmd_fifo: synchronous token FIFO with full/empty flags.
// DEPTH must be a power of two; pointers carry one wrap bit.
module mode_cmd_fifo
  import mode_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  tok_t wr_data,
  input  logic pop,
  output tok_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  tok_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/mode_cmd_arbiter.sv
// mode_cmd_arbiter: merges button edges and UART bytes into ordered mode updates.
// Define MODE_CMD_ECHO_EN to add a tx echo of '0'+mode_lr after each applied token.
module mode_cmd_arbiter
  import mode_cmd_pkg::*;
#(
  parameter int LR_MODES   = 4,
  parameter int UD_MODES   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP       = 1
) (
  input  logic                        clk_1MHz,
  input  logic                        rst_n,
  input  logic                        btn_l,
  input  logic                        btn_r,
  input  logic                        btn_u,
  input  logic                        btn_d,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        rx_ren,
  output logic [$clog2(LR_MODES)-1:0] mode_lr,
  output logic [$clog2(UD_MODES)-1:0] mode_ud,
  output logic                        mode_changed,
  output logic                        cmd_err,
  output logic                        ovf
`ifdef MODE_CMD_ECHO_EN
  ,
  output logic [7:0]                  tx_data,
  output logic                        tx_send,
  input  logic                        tx_ready
`endif
);

  localparam int LW = $clog2(LR_MODES);
  localparam int UW = $clog2(UD_MODES);
  localparam logic [LW-1:0] LR_MAX = LW'(LR_MODES - 1);
  localparam logic [UW-1:0] UD_MAX = UW'(UD_MODES - 1);
  localparam logic [LW-1:0] LR_ONE = LW'(1);
  localparam logic [UW-1:0] UD_ONE = UW'(1);
  localparam bit WRAP_EN = (WRAP != 0);

  logic [3:0]    btn;
  logic [3:0]    btn_q;
  logic [3:0]    rise;
  logic [4:0]    pend;
  logic [4:0]    grant;
  logic          ff1;
  logic          vsync;
  rx_state_e     rx_state;
  rx_state_e     rx_next;
  logic          take;
  logic          is_l, is_r, is_u, is_d;
  logic          is_dig, is_eol;
  logic [7:0]    dig;
  logic          dec_ok;
  logic          dec_err;
  tok_t          dec_tok;
  tok_t          uart_tok;
  tok_t          push_tok;
  tok_t          pop_tok;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [LW-1:0] lr_nx;
  logic [UW-1:0] ud_nx;

  assign btn  = {btn_d, btn_u, btn_r, btn_l};
  assign rise = btn & ~btn_q;

  assign dig    = rx_data - ASC_0;
  assign is_l   = ci_match(rx_data, ASC_L);
  assign is_r   = ci_match(rx_data, ASC_R);
  assign is_u   = ci_match(rx_data, ASC_U);
  assign is_d   = ci_match(rx_data, ASC_D);
  assign is_dig = (rx_data >= ASC_0) && (rx_data <= ASC_9);
  assign is_eol = (rx_data == ASC_CR) || (rx_data == ASC_LF);

  always_comb begin
    dec_ok  = 1'b0;
    dec_err = 1'b0;
    dec_tok = '{op: TOK_LR_DEC, val: 4'd0};
    unique case (1'b1)
      is_l: dec_ok = 1'b1;
      is_r: begin
        dec_ok     = 1'b1;
        dec_tok.op = TOK_LR_INC;
      end
      is_u: begin
        dec_ok     = 1'b1;
        dec_tok.op = TOK_UD_DEC;
      end
      is_d: begin
        dec_ok     = 1'b1;
        dec_tok.op = TOK_UD_INC;
      end
      is_dig: begin
        dec_ok  = (dig < 8'(LR_MODES));
        dec_err = !dec_ok;
        dec_tok = '{op: TOK_LR_SET, val: dig[3:0]};
      end
      is_eol: ;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      ff1      <= 1'b0;
      vsync    <= 1'b0;
      rx_state <= RX_IDLE;
    end else begin
      ff1      <= rx_valid;
      vsync    <= ff1;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE: if (vsync) rx_next = RX_ACK;
      RX_ACK:  if (!vsync) rx_next = RX_IDLE;
    endcase
  end

  assign take   = (rx_state == RX_IDLE) && vsync;
  assign rx_ren = (rx_state == RX_ACK);

  // lowest set bit wins: L > R > U > D > UART
  assign grant = full ? 5'd0 : (pend & (~pend + 5'd1));
  assign push  = |grant;

  always_comb begin
    push_tok = uart_tok;
    unique case (1'b1)
      grant[0]: push_tok = '{op: TOK_LR_DEC, val: 4'd0};
      grant[1]: push_tok = '{op: TOK_LR_INC, val: 4'd0};
      grant[2]: push_tok = '{op: TOK_UD_DEC, val: 4'd0};
      grant[3]: push_tok = '{op: TOK_UD_INC, val: 4'd0};
      default: ;
    endcase
  end

  assign drop = (|(rise & pend[3:0])) | (take & dec_ok & pend[4]);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      btn_q    <= '0;
      pend     <= '0;
      uart_tok <= '{op: TOK_LR_DEC, val: 4'd0};
      ovf      <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      btn_q <= btn;
      pend  <= (pend & ~grant) | ({take & dec_ok, rise} & ~pend);
      if (take && dec_ok && !pend[4])
        uart_tok <= dec_tok;
      ovf     <= ovf | drop;
      cmd_err <= take & dec_err;
    end
  end

  mode_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_1MHz),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_tok),
    .pop     (pop),
    .rd_data (pop_tok),
    .full    (full),
    .empty   (empty)
  );

  assign pop = !empty;

  always_comb begin
    lr_nx = mode_lr;
    ud_nx = mode_ud;
    if (pop) begin
      unique case (pop_tok.op)
        TOK_LR_DEC:
          if (mode_lr != '0) lr_nx = mode_lr - LR_ONE;
          else if (WRAP_EN) lr_nx = LR_MAX;
        TOK_LR_INC:
          if (mode_lr != LR_MAX) lr_nx = mode_lr + LR_ONE;
          else if (WRAP_EN) lr_nx = '0;
        TOK_UD_DEC:
          if (mode_ud != '0) ud_nx = mode_ud - UD_ONE;
          else if (WRAP_EN) ud_nx = UD_MAX;
        TOK_UD_INC:
          if (mode_ud != UD_MAX) ud_nx = mode_ud + UD_ONE;
          else if (WRAP_EN) ud_nx = '0;
        TOK_LR_SET: lr_nx = LW'(pop_tok.val);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_lr      <= '0;
      mode_ud      <= '0;
      mode_changed <= 1'b0;
    end else begin
      mode_lr      <= lr_nx;
      mode_ud      <= ud_nx;
      mode_changed <= (lr_nx != mode_lr) || (ud_nx != mode_ud);
    end
  end

`ifdef MODE_CMD_ECHO_EN
  logic       echo_full;
  logic [7:0] echo_data;

  // a newer token overwrites an echo still waiting for tx_ready
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      echo_full <= 1'b0;
      echo_data <= '0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
    end else begin
      tx_send <= echo_full & tx_ready;
      if (echo_full && tx_ready)
        tx_data <= echo_data;
      if (pop) begin
        echo_full <= 1'b1;
        echo_data <= ASC_0 + 8'(lr_nx);
      end else if (tx_ready) begin
        echo_full <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mode_cmd_arbiter.sv
// tb_mode_cmd_arbiter: directed checks of two instances,
// default (WRAP=1, depth 4) and saturating (WRAP=0, depth 2).
module tb_mode_cmd_arbiter;

  logic clk_1MHz = 1'b0;
  always #5 clk_1MHz = ~clk_1MHz;

  logic       rst_n;
  logic [3:0] ba;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ren;
  logic [1:0] mode_lr;
  logic [0:0] mode_ud;
  logic       mode_changed;
  logic       cmd_err;
  logic       ovf;

  logic [3:0] bb;
  logic       rx_ren2;
  logic [1:0] lr2;
  logic [0:0] ud2;
  logic       chg2;
  logic       err2;
  logic       ovf2;

  int n_chk  = 0;
  int n_fail = 0;

  mode_cmd_arbiter dut_a (
    .clk_1MHz     (clk_1MHz),
    .rst_n        (rst_n),
    .btn_l        (ba[0]),
    .btn_r        (ba[1]),
    .btn_u        (ba[2]),
    .btn_d        (ba[3]),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ren       (rx_ren),
    .mode_lr      (mode_lr),
    .mode_ud      (mode_ud),
    .mode_changed (mode_changed),
    .cmd_err      (cmd_err),
    .ovf          (ovf)
  );

  mode_cmd_arbiter #(
    .FIFO_DEPTH(2),
    .WRAP(0)
  ) dut_b (
    .clk_1MHz     (clk_1MHz),
    .rst_n        (rst_n),
    .btn_l        (bb[0]),
    .btn_r        (bb[1]),
    .btn_u        (bb[2]),
    .btn_d        (bb[3]),
    .rx_valid     (1'b0),
    .rx_data      (8'h00),
    .rx_ren       (rx_ren2),
    .mode_lr      (lr2),
    .mode_ud      (ud2),
    .mode_changed (chg2),
    .cmd_err      (err2),
    .ovf          (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1MHz);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic press_a(input int i);
    ba[i] = 1'b1;
    tick(1);
    ba[i] = 1'b0;
    tick(3);
  endtask

  task automatic press_b(input int i);
    bb[i] = 1'b1;
    tick(1);
    bb[i] = 1'b0;
    tick(3);
  endtask

  task automatic uart_byte(input logic [7:0] b, input logic err);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(3);
    check("err_pulse", 32'(cmd_err), 32'(err));
    tick(1);
    check("err_after", 32'(cmd_err), 32'd0);
    rx_valid = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n    = 1'b0;
    ba       = '0;
    bb       = '0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);
    check("rst_lr", 32'(mode_lr), 32'd0);
    check("rst_ud", 32'(mode_ud), 32'd0);
    check("rst_chg", 32'(mode_changed), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_ren", 32'(rx_ren), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // btn_r latency: sampled at k, visible after k+2
    ba[1] = 1'b1;
    tick(1);
    check("lat_k", 32'(mode_lr), 32'd0);
    ba[1] = 1'b0;
    tick(1);
    check("lat_k1", 32'(mode_lr), 32'd0);
    check("lat_k1_chg", 32'(mode_changed), 32'd0);
    tick(1);
    check("lat_k2", 32'(mode_lr), 32'd1);
    check("lat_k2_chg", 32'(mode_changed), 32'd1);
    tick(1);
    check("chg_once", 32'(mode_changed), 32'd0);

    press_a(1);
    press_a(1);
    check("lr_three", 32'(mode_lr), 32'd3);
    press_a(1);
    check("lr_wrap", 32'(mode_lr), 32'd0);

    // 'u' held for ~50 cycles
    rx_data  = "u";
    rx_valid = 1'b1;
    tick(2);
    check("ren_pre", 32'(rx_ren), 32'd0);
    tick(1);
    check("ren_on", 32'(rx_ren), 32'd1);
    check("u_noerr", 32'(cmd_err), 32'd0);
    tick(48);
    check("ren_hold", 32'(rx_ren), 32'd1);
    check("u_ud", 32'(mode_ud), 32'd1);
    rx_valid = 1'b0;
    tick(2);
    check("ren_tail", 32'(rx_ren), 32'd1);
    tick(1);
    check("ren_off", 32'(rx_ren), 32'd0);
    check("u_once", 32'(mode_ud), 32'd1);

    uart_byte("7", 1'b1);
    check("bad7_lr", 32'(mode_lr), 32'd0);
    uart_byte("2", 1'b0);
    check("set2_lr", 32'(mode_lr), 32'd2);
    uart_byte(8'h0A, 1'b0);
    check("lf_lr", 32'(mode_lr), 32'd2);
    check("lf_ud", 32'(mode_ud), 32'd1);
    check("lf_ovf", 32'(ovf), 32'd0);

    // L,R,U edges together plus 'D': order L,R,U,D
    do_reset();
    ba       = 4'b0111;
    rx_data  = "D";
    rx_valid = 1'b1;
    tick(1);
    ba = 4'b0000;
    tick(1);
    check("ord_k1", 32'(mode_lr), 32'd0);
    tick(1);
    check("ord_L_lr", 32'(mode_lr), 32'd3);
    check("ord_L_ud", 32'(mode_ud), 32'd0);
    tick(1);
    check("ord_R_lr", 32'(mode_lr), 32'd0);
    check("ord_R_ud", 32'(mode_ud), 32'd0);
    tick(1);
    check("ord_U_ud", 32'(mode_ud), 32'd1);
    tick(1);
    check("ord_D_ud", 32'(mode_ud), 32'd0);
    check("ord_D_lr", 32'(mode_lr), 32'd0);
    check("ord_ovf", 32'(ovf), 32'd0);
    check("ord_ren", 32'(rx_ren), 32'd1);

    // reset mid-handshake
    rst_n = 1'b0;
    #1;
    check("rst_ren_now", 32'(rx_ren), 32'd0);
    rx_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rst_hs_ren", 32'(rx_ren), 32'd0);
    check("rst_hs_ud", 32'(mode_ud), 32'd0);
    check("rst_hs_lr", 32'(mode_lr), 32'd0);

    // WRAP=0 instance: saturation at top
    press_b(1);
    press_b(1);
    press_b(1);
    check("sat_three", 32'(lr2), 32'd3);
    bb[1] = 1'b1;
    tick(1);
    bb[1] = 1'b0;
    tick(2);
    check("sat_lr", 32'(lr2), 32'd3);
    check("sat_chg", 32'(chg2), 32'd0);
    tick(1);

    // all four edges at once, depth 2
    do_reset();
    bb = 4'b1111;
    tick(1);
    bb = 4'b0000;
    tick(2);
    check("b_L_lr", 32'(lr2), 32'd0);
    check("b_L_chg", 32'(chg2), 32'd0);
    tick(1);
    check("b_R_lr", 32'(lr2), 32'd1);
    check("b_R_chg", 32'(chg2), 32'd1);
    tick(1);
    check("b_U_ud", 32'(ud2), 32'd0);
    check("b_U_chg", 32'(chg2), 32'd0);
    tick(1);
    check("b_D_ud", 32'(ud2), 32'd1);
    check("b_D_chg", 32'(chg2), 32'd1);
    check("b_ovf0", 32'(ovf2), 32'd0);
    tick(2);

    // re-edge on still-pending D
    bb = 4'b1111;
    tick(1);
    bb = 4'b0000;
    tick(1);
    bb[3] = 1'b1;
    tick(1);
    check("ovf_set", 32'(ovf2), 32'd1);
    bb = 4'b0000;
    tick(6);
    check("ovf_lr", 32'(lr2), 32'd1);
    check("ovf_ud", 32'(ud2), 32'd1);
    tick(10);
    check("ovf_sticky", 32'(ovf2), 32'd1);
    check("a_ovf_clean", 32'(ovf), 32'd0);
    do_reset();
    check("ovf_clr", 32'(ovf2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
